// File: rtl/scaler_nn_par.sv
// -----------------------------------------------------------------------------
// scaler_nn_par
//
// Nearest-neighbour frame scaler with a single line buffer. Source pixels
// arrive in raster order. Only the source row that the current destination
// row maps to is stored. Every other source row is consumed and dropped.
// Each destination row is then read out of the buffer with a column map.
// Row and column indices come from accumulators, not multipliers.
//
// Ports
//   clk          single clock
//   rstn         synchronous active-low reset
//   frame_start  start pulse; only accepted in IDLE with nonzero sizes
//   x_scale      source step per destination column (FRAC fractional bits)
//   y_scale      source step per destination row    (FRAC fractional bits)
//   src_h_num    source row width       (clamped to MAX_H)
//   src_v_num    source row count
//   dst_h_num    destination row width  (clamped to MAX_H)
//   dst_v_num    destination row count
//   in_valid     source pixel valid
//   in_data      source pixel
//   in_ready     source pixel accept (FILL / DRAIN)
//   out_valid    destination pixel valid
//   out_ready    destination pixel accept
//   out_data     destination pixel (registered)
//   out_eol      last pixel of a destination row
//   out_eof      last pixel of the frame
//   ddr_addr     frame write base address, captured at frame start
//   busy         frame in progress
//
// Build option
//   SCALER_CENTER_EN  when defined, ddr_addr is the offset that centres the
//                     destination frame inside a MAX_H x MAX_V canvas.
//                     Otherwise ddr_addr is tied to 0.
//
// States
//   IDLE  | waiting for an accepted frame_start
//   FILL  | consuming source rows; the target row goes into the line buffer
//   EMIT  | reading one destination row out of the line buffer
//   DRAIN | discarding the source rows left after the last destination row
// -----------------------------------------------------------------------------
module scaler_nn_par #(
    parameter int PIX_WIDTH = 16,
    parameter int FIX_LEN   = 15,
    parameter int FRAC      = 11,
    parameter int MAX_H     = 1920,
    parameter int MAX_V     = 1080,
    parameter int CNT_W     = 13,
    parameter int DDR_AW    = 28
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 frame_start,
    input  logic [FIX_LEN-1:0]   x_scale,
    input  logic [FIX_LEN-1:0]   y_scale,
    input  logic [CNT_W-1:0]     src_h_num,
    input  logic [CNT_W-1:0]     src_v_num,
    input  logic [CNT_W-1:0]     dst_h_num,
    input  logic [CNT_W-1:0]     dst_v_num,
    input  logic                 in_valid,
    input  logic [PIX_WIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PIX_WIDTH-1:0] out_data,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic [DDR_AW-1:0]    ddr_addr,
    output logic                 busy
);

    localparam int ACC_W = CNT_W + FRAC;
    localparam int LB_AW = (MAX_H > 1) ? $clog2(MAX_H) : 1;
    localparam logic [CNT_W-1:0] MAX_H_C = CNT_W'(MAX_H);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Parameter sanity: the line buffer address is a slice of a CNT_W count,
    // and the centring canvas needs a real height.
    if (MAX_H < 1 || MAX_H > (2 ** CNT_W) - 1 || LB_AW > CNT_W) begin : g_bad_max_h
        $error("scaler_nn_par: MAX_H out of range for CNT_W");
    end
    if (MAX_V < 1) begin : g_bad_max_v
        $error("scaler_nn_par: MAX_V must be positive");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        EMIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Frame configuration, captured on the accepted frame_start
    logic [FIX_LEN-1:0] cfg_x_scale;
    logic [FIX_LEN-1:0] cfg_y_scale;
    logic [CNT_W-1:0]   cfg_src_h;
    logic [CNT_W-1:0]   cfg_src_v;
    logic [CNT_W-1:0]   cfg_dst_h;
    logic [CNT_W-1:0]   cfg_dst_v;

    // Source side position: column in the row, completed source rows
    logic [CNT_W-1:0]   src_col;
    logic [CNT_W-1:0]   src_row;
    // Source row that the current destination row maps to (the buffered row)
    logic [CNT_W-1:0]   tgt_row;

    // Destination side position and the two index accumulators
    logic [CNT_W-1:0]   dst_col;
    logic [CNT_W-1:0]   dst_row;
    logic [ACC_W-1:0]   x_acc;
    logic [ACC_W-1:0]   y_acc;

    logic [PIX_WIDTH-1:0] lbuf [MAX_H];

    logic [CNT_W-1:0]   src_h_clamp;
    logic [CNT_W-1:0]   dst_h_clamp;
    logic               start_ok;
    logic               in_fire;
    logic               last_src_col;
    logic               row_is_tgt;
    logic               out_free;
    logic               row_done;
    logic               issue;
    logic               row_end;
    logic               last_dst_row;
    logic               src_left;
    logic [ACC_W-1:0]   y_acc_nxt;
    logic [CNT_W-1:0]   tgt_nxt;
    logic [CNT_W-1:0]   rd_idx;

    // Integer part of an accumulator, clamped to the last valid index
    function automatic logic [CNT_W-1:0] clamp_idx(input logic [ACC_W-1:0] acc,
                                                   input logic [CNT_W-1:0] lim);
        logic [CNT_W-1:0] idx;
        idx = acc[ACC_W-1:FRAC];
        return (idx > lim - ONE_C) ? lim - ONE_C : idx;
    endfunction

    assign src_h_clamp = (src_h_num > MAX_H_C) ? MAX_H_C : src_h_num;
    assign dst_h_clamp = (dst_h_num > MAX_H_C) ? MAX_H_C : dst_h_num;

    assign start_ok = frame_start && (state == IDLE) &&
                      (|src_h_num) && (|src_v_num) && (|dst_h_num) && (|dst_v_num);

    assign in_ready     = (state == FILL) || (state == DRAIN);
    assign busy         = (state != IDLE);
    assign in_fire      = in_ready && in_valid;
    assign last_src_col = (src_col == cfg_src_h - ONE_C);
    assign row_is_tgt   = (src_row == tgt_row);

    // A new pixel may enter the output register when it is empty or being
    // taken this cycle. The row only ends once its last pixel has left, so a
    // refill of the line buffer can never disturb a pending output.
    assign out_free     = !out_valid || out_ready;
    assign row_done     = (dst_col == cfg_dst_h);
    assign issue        = (state == EMIT) && !row_done && out_free;
    assign row_end      = (state == EMIT) && row_done && out_free;
    assign last_dst_row = (dst_row == cfg_dst_v - ONE_C);
    assign src_left     = (src_row != cfg_src_v);

    assign y_acc_nxt = y_acc + ACC_W'(cfg_y_scale);
    assign tgt_nxt   = clamp_idx(y_acc_nxt, cfg_src_v);
    assign rd_idx    = clamp_idx(x_acc, cfg_src_h);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (in_fire && last_src_col && row_is_tgt) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (row_end) begin
                    if (last_dst_row) begin
                        state_nxt = src_left ? DRAIN : IDLE;
                    end else if (tgt_nxt != tgt_row) begin
                        state_nxt = FILL;
                    end
                end
            end
            DRAIN: begin
                if (in_fire && last_src_col && (src_row == cfg_src_v - ONE_C)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line buffer write port: only the target source row is stored
    always_ff @(posedge clk) begin
        if (rstn && (state == FILL) && in_fire && row_is_tgt) begin
            lbuf[src_col[LB_AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cfg_x_scale <= '0;
            cfg_y_scale <= '0;
            cfg_src_h   <= '0;
            cfg_src_v   <= '0;
            cfg_dst_h   <= '0;
            cfg_dst_v   <= '0;
            src_col     <= '0;
            src_row     <= '0;
            tgt_row     <= '0;
            dst_col     <= '0;
            dst_row     <= '0;
            x_acc       <= '0;
            y_acc       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_eol     <= 1'b0;
            out_eof     <= 1'b0;
        end else begin
            if (start_ok) begin
                cfg_x_scale <= x_scale;
                cfg_y_scale <= y_scale;
                cfg_src_h   <= src_h_clamp;
                cfg_src_v   <= src_v_num;
                cfg_dst_h   <= dst_h_clamp;
                cfg_dst_v   <= dst_v_num;
                src_col     <= '0;
                src_row     <= '0;
                tgt_row     <= '0;
                dst_col     <= '0;
                dst_row     <= '0;
                x_acc       <= '0;
                y_acc       <= '0;
            end

            if (in_fire) begin
                if (last_src_col) begin
                    src_col <= '0;
                    src_row <= src_row + ONE_C;
                end else begin
                    src_col <= src_col + ONE_C;
                end
            end

            // Synchronous buffer read lands directly in the output register
            if (issue) begin
                out_valid <= 1'b1;
                out_data  <= lbuf[rd_idx[LB_AW-1:0]];
                out_eol   <= (dst_col == cfg_dst_h - ONE_C);
                out_eof   <= (dst_col == cfg_dst_h - ONE_C) && last_dst_row;
                dst_col   <= dst_col + ONE_C;
                x_acc     <= x_acc + ACC_W'(cfg_x_scale);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_eol   <= 1'b0;
                out_eof   <= 1'b0;
            end

            if (row_end) begin
                dst_col <= '0;
                x_acc   <= '0;
                dst_row <= dst_row + ONE_C;
                y_acc   <= y_acc_nxt;
                tgt_row <= tgt_nxt;
            end
        end
    end

`ifdef SCALER_CENTER_EN
    logic [31:0] v_off;
    logic [31:0] h_off;
    logic [31:0] ctr_addr;

    // Offsets are floored at 0 when the destination exceeds the canvas
    always_comb begin
        v_off = '0;
        h_off = '0;
        if (32'(dst_v_num) < 32'(MAX_V)) begin
            v_off = (32'(MAX_V) - 32'(dst_v_num)) >> 1;
        end
        if (32'(dst_h_clamp) < 32'(MAX_H)) begin
            h_off = (32'(MAX_H) - 32'(dst_h_clamp)) >> 1;
        end
        ctr_addr = v_off * 32'(MAX_H) + h_off;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ddr_addr <= '0;
        end else if (start_ok) begin
            ddr_addr <= DDR_AW'(ctr_addr);
        end
    end
`else
    assign ddr_addr = '0;
`endif

endmodule
